// File: rtl/trojan_chk_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | trojan_chk_pkg                                                             |
// | Shared state encoding and default sizes for the Trojan frame checker.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package trojan_chk_pkg;

  localparam int FRAME_LEN_DEF = 32;
  localparam int CNT_W_DEF     = 16;

  typedef enum logic [0:0] {
    SHIFT = 1'b0,
    CHECK = 1'b1
  } chk_state_t;

endpackage : trojan_chk_pkg
`default_nettype wire

// File: rtl/frame_deser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | frame_deser                                                                |
// | Serial-to-parallel frame shifter with bit counter and last-bit strobe.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module frame_deser
  import trojan_chk_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_in,
  input  logic                 i_bit_valid,
  input  logic                 i_shift_en,
  output logic [FRAME_LEN-1:0] o_shreg,
  output logic                 o_last_bit
);

  localparam int                c_BIT_W = $clog2(FRAME_LEN);
  localparam logic [c_BIT_W-1:0] c_LAST  = c_BIT_W'(FRAME_LEN - 1);

  logic [FRAME_LEN-1:0] r_shreg;
  logic [c_BIT_W-1:0]   r_bit_cnt;
  logic                 w_accept;
  logic                 w_last_bit;

  // Bits offered while the checker is busy comparing are dropped, not queued.
  assign w_accept   = i_shift_en & i_bit_valid;
  assign w_last_bit = w_accept & (r_bit_cnt == c_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shreg   <= '0;
      r_bit_cnt <= '0;
    end else if (w_accept) begin
      r_shreg   <= {r_shreg[FRAME_LEN-2:0], i_in};
      r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + c_BIT_W'(1);
    end
  end

  assign o_shreg    = r_shreg;
  assign o_last_bit = w_last_bit;

endmodule : frame_deser
`default_nettype wire

// File: rtl/trojan_frame_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | trojan_frame_checker                                                       |
// | Frame-wise comparison of suspect vs golden core outputs with sticky flag.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module trojan_frame_checker
  import trojan_chk_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in,
  input  logic                 bit_valid,
  input  logic                 dut_out,
  input  logic                 gold_out,
  output logic                 frame_done,
  output logic [FRAME_LEN-1:0] frame_data,
  output logic [CNT_W-1:0]     frame_count,
  output logic [CNT_W-1:0]     mismatch_count,
  output logic                 detected,
  output logic [FRAME_LEN-1:0] fail_frame,
  output logic [CNT_W-1:0]     fail_index
);

  chk_state_t           r_state;
  chk_state_t           w_state_nxt;
  logic                 w_check;
  logic                 w_mismatch;
  logic [FRAME_LEN-1:0] w_shreg;
  logic                 w_last_bit;

  logic                 r_frame_done;
  logic [FRAME_LEN-1:0] r_frame_data;
  logic [CNT_W-1:0]     r_frame_count;
  logic [CNT_W-1:0]     r_mismatch_count;
  logic                 r_detected;
  logic [FRAME_LEN-1:0] r_fail_frame;
  logic [CNT_W-1:0]     r_fail_index;

  frame_deser #(
    .FRAME_LEN (FRAME_LEN)
  ) u_deser (
    .clk         (clk),
    .reset       (reset),
    .i_in        (in),
    .i_bit_valid (bit_valid),
    .i_shift_en  (r_state == SHIFT),
    .o_shreg     (w_shreg),
    .o_last_bit  (w_last_bit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= SHIFT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_check     = 1'b0;
    case (r_state)
      SHIFT: if (w_last_bit) w_state_nxt = CHECK;
      CHECK: begin
        w_check     = 1'b1;
        w_state_nxt = SHIFT;
      end
      default: w_state_nxt = SHIFT;
    endcase
  end

  assign w_mismatch = w_check & (dut_out != gold_out);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_done     <= 1'b0;
      r_frame_data     <= '0;
      r_frame_count    <= '0;
      r_mismatch_count <= '0;
      r_detected       <= 1'b0;
      r_fail_frame     <= '0;
      r_fail_index     <= '0;
    end else begin
      r_frame_done <= w_check;
      if (w_check) begin
        r_frame_data  <= w_shreg;
        r_frame_count <= r_frame_count + CNT_W'(1);
      end
      if (w_mismatch) begin
        if (r_mismatch_count != '1)
          r_mismatch_count <= r_mismatch_count + CNT_W'(1);
        // Only the first offending frame is kept; later ones just count.
        if (!r_detected) begin
          r_detected   <= 1'b1;
          r_fail_frame <= w_shreg;
          r_fail_index <= r_frame_count;
        end
      end
    end
  end

  assign frame_done     = r_frame_done;
  assign frame_data     = r_frame_data;
  assign frame_count    = r_frame_count;
  assign mismatch_count = r_mismatch_count;
  assign detected       = r_detected;
  assign fail_frame     = r_fail_frame;
  assign fail_index     = r_fail_index;

endmodule : trojan_frame_checker
`default_nettype wire

// File: tb/tb_trojan_frame_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_trojan_frame_checker                                                    |
// | Directed self-checking bench for trojan_frame_checker.                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_trojan_frame_checker;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in = 1'b0;
  logic bit_valid = 1'b0;
  logic dut_out = 1'b0;
  logic gold_out = 1'b0;

  logic        frame_done;
  logic [31:0] frame_data;
  logic [15:0] frame_count;
  logic [15:0] mismatch_count;
  logic        detected;
  logic [31:0] fail_frame;
  logic [15:0] fail_index;

  logic        frame_done4;
  logic [31:0] frame_data4;
  logic [3:0]  frame_count4;
  logic [3:0]  mismatch_count4;
  logic        detected4;
  logic [31:0] fail_frame4;
  logic [3:0]  fail_index4;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int done_base;

  always #5 clk = ~clk;

  trojan_frame_checker #(.FRAME_LEN(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in(in), .bit_valid(bit_valid),
    .dut_out(dut_out), .gold_out(gold_out),
    .frame_done(frame_done), .frame_data(frame_data), .frame_count(frame_count),
    .mismatch_count(mismatch_count), .detected(detected),
    .fail_frame(fail_frame), .fail_index(fail_index)
  );

  // Narrow-counter instance sees the same stream but always mismatches.
  trojan_frame_checker #(.FRAME_LEN(32), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .in(in), .bit_valid(bit_valid),
    .dut_out(1'b1), .gold_out(1'b0),
    .frame_done(frame_done4), .frame_data(frame_data4), .frame_count(frame_count4),
    .mismatch_count(mismatch_count4), .detected(detected4),
    .fail_frame(fail_frame4), .fail_index(fail_index4)
  );

  always @(negedge clk) if (frame_done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic b);
    bit_valid = v;
    in        = b;
    @(posedge clk);
    #1;
  endtask

  // Sends 32 bits MSB first, skipping a cycle before each bit flagged in gaps,
  // then spends the CHECK slot offering (chk_v, chk_b).
  task automatic send_frame(input logic [31:0] data, input logic d, input logic g,
                            input logic [31:0] gaps, input logic chk_v, input logic chk_b);
    dut_out  = d;
    gold_out = g;
    for (int i = 31; i >= 0; i--) begin
      if (gaps[i]) step(1'b0, ~data[i]);
      step(1'b1, data[i]);
    end
    step(chk_v, chk_b);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bit_valid = 1'b0;
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_mismatch_count", mismatch_count, 0);
    chk("rst_detected", detected, 0);
    chk("rst_frame_data", frame_data, 0);
    chk("rst_fail_index", fail_index, 0);
    reset = 1'b0;
    step(1'b0, 1'b0);

    // Reset mid-frame discards the partial frame
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1);
    do_reset();
    send_frame(32'hA5A5_0F0F, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("midrst_frame_count", frame_count, 1);
    chk("midrst_detected", detected, 0);
    chk("midrst_frame_data", frame_data, 32'hA5A5_0F0F);

    // Frame ordering and result latency
    send_frame(32'hF54C_62D1, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
    chk("order_frame_done", frame_done, 1);
    chk("order_frame_data", frame_data, 32'hF54C_62D1);
    chk("order_mismatch_count", mismatch_count, 0);
    chk("order_frame_count", frame_count, 2);
    step(1'b0, 1'b0);
    chk("order_done_pulse_end", frame_done, 0);

    // First mismatch capture and later mismatch
    do_reset();
    send_frame(32'h1111_1111, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    send_frame(32'h2222_2222, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
    send_frame(32'h3333_3333, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("pre_detected", detected, 0);
    send_frame(32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("mm1_detected", detected, 1);
    chk("mm1_fail_index", fail_index, 3);
    chk("mm1_fail_frame", fail_frame, 32'hDEAD_BEEF);
    chk("mm1_mismatch_count", mismatch_count, 1);
    send_frame(32'h4444_4444, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    send_frame(32'h1234_5678, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    chk("mm2_mismatch_count", mismatch_count, 2);
    chk("mm2_fail_index", fail_index, 3);
    chk("mm2_fail_frame", fail_frame, 32'hDEAD_BEEF);
    chk("mm2_frame_count", frame_count, 6);
    chk("mm2_frame_data", frame_data, 32'h1234_5678);

    // Gapped input: seven idle cycles scattered through the frame
    step(1'b0, 1'b0);
    done_base = done_cnt;
    send_frame(32'hF54C_62D1, 1'b1, 1'b1, 32'h8041_8421, 1'b0, 1'b0);
    chk("gap_frame_data", frame_data, 32'hF54C_62D1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("gap_done_once", 32'(done_cnt - done_base), 1);
    chk("gap_frame_count", frame_count, 7);

    // CHECK-slot bit is ignored
    send_frame(32'h0F0F_3C3C, 1'b1, 1'b1, 32'h0, 1'b1, 1'b1);
    chk("iso_first_frame", frame_data, 32'h0F0F_3C3C);
    dut_out = 1'b0;
    gold_out = 1'b0;
    for (int i = 31; i >= 1; i--) step(1'b1, i[0]);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("iso_not_early", frame_count, 8);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("iso_frame_count", frame_count, 9);
    chk("iso_frame_data", frame_data, 32'hAAAA_AAAA);

    // Saturation and wrap on the 4-bit counter instance
    do_reset();
    for (int f = 0; f < 20; f++) send_frame(32'hC0DE_0000 | 32'(f), 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("sat_mismatch_count", mismatch_count4, 4'hF);
    chk("sat_frame_count", frame_count4, 4);
    chk("sat_detected", detected4, 1);
    chk("sat_fail_index", fail_index4, 0);
    chk("sat_fail_frame", fail_frame4, 32'hC0DE_0000);
    chk("sat_main_frame_count", frame_count, 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule : tb_trojan_frame_checker
`default_nettype wire
